// File: rtl/laser_pkg.sv
// Shared constants, state encoding and point type for the LASER host and its coverage checker.
package laser_pkg;

    localparam int NPTS      = 40;
    localparam int RADIUS_SQ = 16;
    localparam int CW        = 4;
    localparam int NW        = 6;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KICK   = 3'd1,
        STREAM = 3'd2,
        WAIT   = 3'd3,
        SCORE  = 3'd4,
        REPORT = 3'd5
    } state_t;

    typedef struct packed {
        logic [CW-1:0] y;
        logic [CW-1:0] x;
    } pt_t;

    function automatic logic [CW-1:0] absdiff(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/laser_cover_chk.sv
// Combinational coverage test: a point is covered when it lies within RSQ (squared distance) of either center.
module laser_cover_chk
    import laser_pkg::*;
#(
    parameter int RSQ = RADIUS_SQ
) (
    input  pt_t  i_pt,
    input  pt_t  i_c1,
    input  pt_t  i_c2,
    output logic o_covered
);

    logic [CW-1:0] w_dx1, w_dy1, w_dx2, w_dy2;
    logic [7:0]    w_sx1, w_sy1, w_sx2, w_sy2;
    logic [8:0]    w_d1, w_d2;

    assign w_dx1 = absdiff(i_pt.x, i_c1.x);
    assign w_dy1 = absdiff(i_pt.y, i_c1.y);
    assign w_dx2 = absdiff(i_pt.x, i_c2.x);
    assign w_dy2 = absdiff(i_pt.y, i_c2.y);

    assign w_sx1 = {4'b0, w_dx1} * {4'b0, w_dx1};
    assign w_sy1 = {4'b0, w_dy1} * {4'b0, w_dy1};
    assign w_sx2 = {4'b0, w_dx2} * {4'b0, w_dx2};
    assign w_sy2 = {4'b0, w_dy2} * {4'b0, w_dy2};

    // 9-bit sums: two 225s must not wrap into the covered range
    assign w_d1 = {1'b0, w_sx1} + {1'b0, w_sy1};
    assign w_d2 = {1'b0, w_sx2} + {1'b0, w_sy2};

    assign o_covered = (w_d1 <= 9'(RSQ)) || (w_d2 <= 9'(RSQ));

endmodule

// File: rtl/laser_host.sv
// Host driver for the LASER solver: loads a frame, streams it, captures the centers and scores coverage.
// result_valid follows start by 1 + NPTS + solver latency + NPTS + 1 cycles; start is ignored while busy.
module laser_host #(
    parameter int NPTS      = laser_pkg::NPTS,
    parameter int RADIUS_SQ = laser_pkg::RADIUS_SQ,
    parameter int TIMEOUT   = 65535
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       wr_en,
    input  logic [5:0] wr_addr,
    input  logic [3:0] wr_x,
    input  logic [3:0] wr_y,
    input  logic       start,
    input  logic [5:0] exp_cnt,
    output logic       LRST,
    output logic [3:0] X,
    output logic [3:0] Y,
    input  logic       DONE,
    input  logic [3:0] C1X,
    input  logic [3:0] C1Y,
    input  logic [3:0] C2X,
    input  logic [3:0] C2Y,
    output logic       busy,
    output logic       result_valid,
    output logic [5:0] cover_cnt,
    output logic       pass,
    output logic       timeout,
    output logic [7:0] c1_q,
    output logic [7:0] c2_q
);

    import laser_pkg::*;

    localparam logic [NW-1:0] LAST = NW'(NPTS - 1);
    // Leaving WAIT when the timer would reach TIMEOUT-1 puts REPORT exactly TIMEOUT cycles after the stream
    localparam logic [15:0]   TLIM = 16'(TIMEOUT - 2);

    state_t        r_state, w_nxt;
    pt_t           r_mem [NPTS];
    logic [NW-1:0] r_idx, r_acc, r_exp, w_sum;
    logic [15:0]   r_tmr;
    logic          r_pass, r_timeout;
    pt_t           r_c1, r_c2;
    pt_t           w_pt;
    logic          w_cov, w_last;

    assign w_pt   = r_mem[r_idx];
    assign w_last = (r_idx == LAST);
    assign w_sum  = r_acc + NW'(w_cov);

    always_ff @(posedge CLK) begin
        if (wr_en && (wr_addr <= LAST) && (r_state != STREAM))
            r_mem[wr_addr] <= '{y: wr_y, x: wr_x};
    end

    laser_cover_chk #(.RSQ(RADIUS_SQ)) u_chk (
        .i_pt      (w_pt),
        .i_c1      (r_c1),
        .i_c2      (r_c2),
        .o_covered (w_cov)
    );

    always_comb begin
        w_nxt        = r_state;
        LRST         = 1'b0;
        X            = '0;
        Y            = '0;
        busy         = (r_state != IDLE);
        result_valid = 1'b0;
        case (r_state)
            IDLE: begin
                LRST = 1'b1;
                if (start) w_nxt = KICK;
            end
            KICK: begin
                LRST  = 1'b1;
                X     = w_pt.x;
                Y     = w_pt.y;
                w_nxt = STREAM;
            end
            STREAM: begin
                X = w_pt.x;
                Y = w_pt.y;
                if (w_last) w_nxt = WAIT;
            end
            WAIT: begin
                if (DONE)               w_nxt = SCORE;
                else if (r_tmr == TLIM) w_nxt = REPORT;
            end
            SCORE: begin
                if (w_last) w_nxt = REPORT;
            end
            REPORT: begin
                result_valid = 1'b1;
                w_nxt        = IDLE;
            end
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_acc     <= '0;
            r_exp     <= '0;
            r_tmr     <= '0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
            r_c1      <= '0;
            r_c2      <= '0;
        end else begin
            r_state <= w_nxt;
            case (r_state)
                IDLE: begin
                    r_idx <= '0;
                    if (start) begin
                        r_exp     <= exp_cnt;
                        r_pass    <= 1'b0;
                        r_timeout <= 1'b0;
                    end
                end
                STREAM: begin
                    r_idx <= w_last ? '0 : r_idx + 1'b1;
                    r_tmr <= '0;
                end
                WAIT: begin
                    r_tmr <= r_tmr + 1'b1;
                    if (DONE) begin
                        r_c1  <= '{y: C1Y, x: C1X};
                        r_c2  <= '{y: C2Y, x: C2X};
                        r_acc <= '0;
                        r_idx <= '0;
                    end else if (r_tmr == TLIM) begin
                        r_timeout <= 1'b1;
                        r_pass    <= 1'b0;
                        r_acc     <= '0;
                    end
                end
                SCORE: begin
                    r_acc <= w_sum;
                    r_idx <= w_last ? '0 : r_idx + 1'b1;
                    if (w_last) r_pass <= (w_sum == r_exp);
                end
                default: ;
            endcase
        end
    end

    assign cover_cnt = r_acc;
    assign pass      = r_pass;
    assign timeout   = r_timeout;
    assign c1_q      = r_c1;
    assign c2_q      = r_c2;

endmodule

// File: tb/tb_laser_host.sv
// Directed bench for laser_host: table of scoring runs plus reset, timeout and stray-input sequences.
module tb_laser_host;

    logic       CLK = 1'b0;
    logic       RST, wr_en, start, DONE;
    logic [5:0] wr_addr, exp_cnt;
    logic [3:0] wr_x, wr_y, C1X, C1Y, C2X, C2Y;
    logic       LRST, busy, result_valid, pass, timeout;
    logic [3:0] X, Y;
    logic [5:0] cover_cnt;
    logic [7:0] c1_q, c2_q;

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] frame [40];

    laser_host #(.TIMEOUT(64)) dut (
        .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y),
        .start(start), .exp_cnt(exp_cnt), .LRST(LRST), .X(X), .Y(Y), .DONE(DONE),
        .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y), .busy(busy), .result_valid(result_valid),
        .cover_cnt(cover_cnt), .pass(pass), .timeout(timeout), .c1_q(c1_q), .c2_q(c2_q)
    );

    always #5 CLK = ~CLK;

    // Points 0..na-1 are pa, the rest pb; centers and points are {y,x}
    typedef struct {
        int         na;
        logic [7:0] pa, pb, c1, c2;
        logic [5:0] exp;
        int         dly;
        logic [5:0] cnt;
        logic       ps;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input int a, input logic [7:0] v);
        wr_en = 1'b1; wr_addr = 6'(a); wr_x = v[3:0]; wr_y = v[7:4];
        step();
        wr_en = 1'b0;
    endtask

    // Point 0 is written by run() in the start cycle itself
    task automatic load(input int na, input logic [7:0] pa, input logic [7:0] pb);
        for (int k = 0; k < 40; k++) frame[k] = (k < na) ? pa : pb;
        for (int k = 1; k < 40; k++) wr(k, frame[k]);
    endtask

    task automatic run(input logic [7:0] c1, input logic [7:0] c2, input logic [5:0] ex,
                       input int dly, input bit do_done, input bit poke,
                       output logic [5:0] cnt, output logic ps, output logic to,
                       output int lat, output int wcnt);
        int cyc;
        exp_cnt = ex; start = 1'b1;
        wr_en = 1'b1; wr_addr = 6'd0; wr_x = frame[0][3:0]; wr_y = frame[0][7:4];
        step();
        start = 1'b0; wr_en = 1'b0; exp_cnt = ~ex; cyc = 1;
        chk("kick_lrst", 32'(LRST), 32'd1);
        chk("kick_xy", 32'({Y, X}), 32'(frame[0]));
        chk("kick_busy", 32'(busy), 32'd1);
        step(); cyc++;
        for (int k = 0; k < 40; k++) begin
            chk($sformatf("stream_lrst[%0d]", k), 32'(LRST), 32'd0);
            chk($sformatf("stream_xy[%0d]", k), 32'({Y, X}), 32'(frame[k]));
            if (poke && k == 10) begin
                start = 1'b1; wr_en = 1'b1; wr_addr = 6'd3;
                wr_x = ~frame[3][3:0]; wr_y = ~frame[3][7:4];
            end
            step(); cyc++;
            start = 1'b0; wr_en = 1'b0;
        end
        chk("wait_xy", 32'({LRST, Y, X}), 32'd0);
        wcnt = 1;
        while (!result_valid && cyc < 400) begin
            DONE = do_done && (wcnt == dly);
            {C1Y, C1X} = DONE ? c1 : ~c1;
            {C2Y, C2X} = DONE ? c2 : ~c2;
            step(); cyc++; wcnt++;
            DONE = 1'b0;
        end
        chk("result_seen", 32'(result_valid), 32'd1);
        lat = cyc; cnt = cover_cnt; ps = pass; to = timeout;
        step();
        chk("rv_pulse", 32'(result_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_lrst", 32'(LRST), 32'd1);
    endtask

    logic [5:0] r_cnt;
    logic       r_ps, r_to;
    int         lat, wcnt, seen;

    initial begin
        RST = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_x = '0; wr_y = '0; start = 1'b0;
        exp_cnt = '0; DONE = 1'b0; C1X = '0; C1Y = '0; C2X = '0; C2Y = '0;
        step(); step(); step();
        chk("rst_lrst", 32'(LRST), 32'd1);
        chk("rst_xy", 32'({Y, X}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rv", 32'(result_valid), 32'd0);
        chk("rst_cnt", 32'(cover_cnt), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_to", 32'(timeout), 32'd0);
        chk("rst_c1", 32'(c1_q), 32'd0);
        chk("rst_c2", 32'(c2_q), 32'd0);
        RST = 1'b0;
        step();

        tbl[0] = '{na: 40, pa: 8'h88, pb: 8'h88, c1: 8'h88, c2: 8'h88, exp: 6'd40, dly: 1,  cnt: 6'd40, ps: 1'b1};
        tbl[1] = '{na: 20, pa: 8'h22, pb: 8'hDD, c1: 8'h22, c2: 8'hDD, exp: 6'd40, dly: 3,  cnt: 6'd40, ps: 1'b1};
        tbl[2] = '{na: 20, pa: 8'h22, pb: 8'hDD, c1: 8'h22, c2: 8'hDD, exp: 6'd39, dly: 7,  cnt: 6'd40, ps: 1'b0};
        tbl[3] = '{na: 10, pa: 8'h04, pb: 8'h14, c1: 8'h00, c2: 8'hFF, exp: 6'd10, dly: 2,  cnt: 6'd10, ps: 1'b1};
        tbl[4] = '{na: 25, pa: 8'h00, pb: 8'h14, c1: 8'hFF, c2: 8'hFF, exp: 6'd0,  dly: 5,  cnt: 6'd0,  ps: 1'b1};
        tbl[5] = '{na: 40, pa: 8'h6F, pb: 8'h6F, c1: 8'h00, c2: 8'h00, exp: 6'd0,  dly: 4,  cnt: 6'd0,  ps: 1'b1};
        tbl[6] = '{na: 17, pa: 8'h3C, pb: 8'hC3, c1: 8'h7C, c2: 8'h80, exp: 6'd20, dly: 10, cnt: 6'd17, ps: 1'b0};

        for (int i = 0; i < 7; i++) begin
            load(tbl[i].na, tbl[i].pa, tbl[i].pb);
            run(tbl[i].c1, tbl[i].c2, tbl[i].exp, tbl[i].dly, 1'b1, 1'b0, r_cnt, r_ps, r_to, lat, wcnt);
            chk($sformatf("row%0d_cnt", i), 32'(r_cnt), 32'(tbl[i].cnt));
            chk($sformatf("row%0d_pass", i), 32'(r_ps), 32'(tbl[i].ps));
            chk($sformatf("row%0d_to", i), 32'(r_to), 32'd0);
            chk($sformatf("row%0d_lat", i), 32'(lat), 32'(82 + tbl[i].dly));
            chk($sformatf("row%0d_c1q", i), 32'(c1_q), 32'(tbl[i].c1));
            chk($sformatf("row%0d_c2q", i), 32'(c2_q), 32'(tbl[i].c2));
        end

        // No DONE: REPORT lands on the 64th cycle after the stream, centers held
        load(20, 8'h22, 8'hDD);
        run(8'h11, 8'h11, 6'd40, 0, 1'b0, 1'b0, r_cnt, r_ps, r_to, lat, wcnt);
        chk("tmo_to", 32'(r_to), 32'd1);
        chk("tmo_pass", 32'(r_ps), 32'd0);
        chk("tmo_cnt", 32'(r_cnt), 32'd0);
        chk("tmo_wcyc", 32'(wcnt), 32'd64);
        chk("tmo_lat", 32'(lat), 32'd105);
        chk("tmo_c1q", 32'(c1_q), 32'h7C);

        // Reset on stream cycle 20
        load(40, 8'h88, 8'h88);
        exp_cnt = 6'd40; start = 1'b1;
        wr_en = 1'b1; wr_addr = 6'd0; wr_x = 4'h8; wr_y = 4'h8;
        step();
        start = 1'b0; wr_en = 1'b0;
        for (int k = 0; k < 21; k++) step();
        chk("rstmid_pre_lrst", 32'(LRST), 32'd0);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("rstmid_lrst", 32'(LRST), 32'd1);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_rv", 32'(result_valid), 32'd0);
        chk("rstmid_xy", 32'({Y, X}), 32'd0);
        chk("rstmid_c1q", 32'(c1_q), 32'd0);
        seen = 0;
        for (int k = 0; k < 150; k++) begin
            if (result_valid || busy) seen++;
            step();
        end
        chk("rstmid_quiet", 32'(seen), 32'd0);
        run(8'h88, 8'h88, 6'd40, 2, 1'b1, 1'b0, r_cnt, r_ps, r_to, lat, wcnt);
        chk("rerun_cnt", 32'(r_cnt), 32'd40);
        chk("rerun_pass", 32'(r_ps), 32'd1);

        // Stray DONE in IDLE, out-of-range write, start and write while busy
        DONE = 1'b1; {C1Y, C1X} = 8'h11; {C2Y, C2X} = 8'h33;
        step();
        DONE = 1'b0;
        chk("stray_c1q", 32'(c1_q), 32'h88);
        chk("stray_c2q", 32'(c2_q), 32'h88);
        chk("stray_busy", 32'(busy), 32'd0);
        wr(45, 8'h00);
        run(8'h88, 8'h88, 6'd40, 3, 1'b1, 1'b1, r_cnt, r_ps, r_to, lat, wcnt);
        chk("poke_pass", 32'(r_ps), 32'd1);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy) seen++;
            step();
        end
        chk("poke_no_rerun", 32'(seen), 32'd0);
        run(8'h88, 8'h88, 6'd40, 1, 1'b1, 1'b0, r_cnt, r_ps, r_to, lat, wcnt);
        chk("final_cnt", 32'(r_cnt), 32'd40);
        chk("final_pass", 32'(r_ps), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/laser_host.md
Name: laser_host

Overview:
- Host-side counterpart to the LASER dual-circle solver.
- Holds a 40-point frame loaded over a write port, resets the solver and streams the points on LASER's X/Y bus.
- Waits for DONE, captures the two returned centers, and rescans the frame to count covered points.
- Reports coverage and pass/fail against an expected count. Used in the system wrapper and as the synthesizable driver in the LASER regression.

Parameters:
- NPTS, 40, points per frame; must equal the solver's frame size.
- RADIUS_SQ, 16, squared radius; a point is covered when dx*dx+dy*dy <= RADIUS_SQ.
- TIMEOUT, 65535, cycles allowed between the last streamed point and DONE.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- wr_en  in  1  frame-buffer write strobe
- wr_addr  in  6  write index, 0..NPTS-1; writes at higher indices are ignored
- wr_x  in  4  point X coordinate
- wr_y  in  4  point Y coordinate
- start  in  1  begin one run; ignored unless idle
- exp_cnt  in  6  expected coverage for the run, sampled on start
- LRST  out  1  solver reset (synchronous, active-high)
- X  out  4  point X coordinate to the solver
- Y  out  4  point Y coordinate to the solver
- DONE  in  1  solver completion pulse
- C1X, C1Y, C2X, C2Y  in  4 each  solver centers, valid in the DONE cycle
- busy  out  1  high from start until result_valid
- result_valid  out  1  one-cycle pulse when a run ends
- cover_cnt  out  6  points covered by the captured centers
- pass  out  1  cover_cnt == exp_cnt and no timeout; valid with result_valid
- timeout  out  1  DONE not seen within TIMEOUT; valid with result_valid
- c1_q, c2_q  out  8 each  captured {Y,X} per center; hold until the next capture

Behaviour:
- Reset values:
  - LRST=1; X=Y=0; busy=0; result_valid=0; cover_cnt=0; pass=0; timeout=0; c1_q=c2_q=0.
  - State IDLE. Frame buffer contents are not reset.
- States:
  - IDLE: LRST held 1. start moves to KICK and latches exp_cnt. A write in the same cycle as start is stored before streaming.
  - KICK: one cycle, LRST=1, X/Y = point 0.
  - STREAM: LRST=0 for NPTS cycles. On stream cycle k (k=0..NPTS-1), X/Y = point k.
    - Point 0 must be on the bus in the first cycle after LRST falls, because the solver samples point 0 in its IDLE cycle.
    - Frame writes during STREAM are blocked (dropped).
  - WAIT: X/Y = 0; the timer counts from 0.
    - DONE=1 captures c1_q={C1Y,C1X} and c2_q={C2Y,C2X}, then moves to SCORE.
    - Timer reaching TIMEOUT-1 moves to REPORT with timeout=1 and cover_cnt=0.
  - SCORE: NPTS cycles, one point per cycle.
    - |dx|,|dy| are 4-bit absolute differences; squares are 8 bits; sum is 9 bits, no overflow.
    - covered = d1<=RADIUS_SQ OR d2<=RADIUS_SQ. A point covered by both centers counts once.
    - The accumulator clears on entry.
  - REPORT: result_valid=1 for one cycle, with pass/timeout/cover_cnt valid; then IDLE. LRST returns to 1 in IDLE.
- DONE outside WAIT is ignored; it does not recapture.
- Latency from the start cycle: result_valid arrives at (1 + NPTS + solver latency + NPTS + 1) cycles.
- RST mid-run: abort at the next edge to IDLE with the reset outputs. result_valid is not produced. LRST is reasserted immediately.
- start while busy: ignored, no queueing.
- wr_addr >= NPTS: write dropped.

Decomposition:
- Shared package laser_pkg: NPTS, RADIUS_SQ, coordinate width 4, count width 6, state encoding (IDLE, KICK, STREAM, WAIT, SCORE, REPORT).
- One sub-module, laser_cover_chk (combinational):
  - Inputs: point, two centers, RADIUS_SQ. Output: covered bit.
  - The same function the solver uses internally. It is reused here so the bench and host share one definition.

Test Plan:
- All 40 points at (8,8); solver returns C1=C2=(8,8); exp_cnt=40 -> cover_cnt=40, pass=1, timeout=0. Check LRST is high exactly in KICK, and X/Y=(8,8) on 40 consecutive cycles after LRST falls.
- 20 points at (2,2) and 20 at (13,13); DONE with C1=(2,2), C2=(13,13); exp_cnt=40 -> pass=1. Repeat with exp_cnt=39 -> pass=0, cover_cnt=40.
- Boundary radius: point (4,0) vs center (0,0) (d=16) covered; point (4,1) (d=17) not covered; point (0,0) vs (15,15) not covered. cover_cnt must match a hand count.
- DONE never asserted, TIMEOUT=64 -> result_valid on the 64th WAIT cycle with timeout=1, pass=0, cover_cnt=0.
- RST asserted on stream cycle 20 -> next cycle LRST=1, busy=0, and no result_valid. A following start with the same frame passes.
- Stray DONE in IDLE, start during busy, and wr_addr=45 -> no capture, no second run, and the frame is unchanged (verified by a rerun).
